// File: rtl/gfx_pkg.sv
// Purpose: shared definitions for the rectangle fill engine (register map, FSM states, pixel word).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gfx_pkg;

    // DLX-visible register offsets
    localparam logic [2:0] REG_X0     = 3'd0;
    localparam logic [2:0] REG_Y0     = 3'd1;
    localparam logic [2:0] REG_W      = 3'd2;
    localparam logic [2:0] REG_H      = 3'd3;
    localparam logic [2:0] REG_COLOR  = 3'd4;
    localparam logic [2:0] REG_CTRL   = 3'd5;
    localparam logic [2:0] REG_STATUS = 3'd6;

    localparam int CTRL_START_BIT   = 0;
    localparam int STATUS_CLEAR_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLIP = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } fill_state_t;

    // Framebuffer word: top byte always zero, 24-bit RGB below it.
    typedef struct packed {
        logic [7:0]  pad;
        logic [23:0] rgb;
    } pixel_word_t;

    function automatic logic [31:0] pack_pixel(input logic [23:0] rgb);
        pixel_word_t w;
        w.pad = 8'h00;
        w.rgb = rgb;
        return w;
    endfunction

endpackage

// File: rtl/gfx_fill_engine.sv
// Purpose: fills a clipped rectangle of the framebuffer with one colour, programmed over a DLX register port.
// Latency: start write at edge N -> first fb_write_enable two cycles later; one pixel per cycle at full rate.
// Backpressure: fb_ready low stalls the fill; fb_address/fb_data_write hold until the write is taken.
//
// Ports:
//   clk, reset                     - sole clock, synchronous active-high reset
//   cfg_address/_data_write/_write_enable/_data_read - register access (read is combinational)
//   fb_address, fb_data_write, fb_write_enable, fb_ready - framebuffer write port (valid/ready)
//   busy, done_irq                 - fill in progress, one-cycle completion pulse
module gfx_fill_engine
    import gfx_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 13,
    parameter int FB_WIDTH      = 128,
    parameter int FB_HEIGHT     = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               cfg_address,
    input  logic [31:0]              cfg_data_write,
    input  logic                     cfg_write_enable,
    output logic [31:0]              cfg_data_read,
    output logic [ADDRESS_WIDTH-1:0] fb_address,
    output logic [31:0]              fb_data_write,
    output logic                     fb_write_enable,
    input  logic                     fb_ready,
    output logic                     busy,
    output logic                     done_irq
);

    localparam int         XW   = $clog2(FB_WIDTH);
    localparam logic [8:0] FBW9 = 9'(FB_WIDTH);
    localparam logic [8:0] FBH9 = 9'(FB_HEIGHT);

    // Programmable registers
    logic [6:0]  x0_q;
    logic [5:0]  y0_q;
    logic [7:0]  w_q;
    logic [6:0]  h_q;
    logic [23:0] color_q;
    logic        done_q;

    // Copies taken at start so register writes during a fill have no effect on it
    logic [8:0]  run_x0;
    logic [8:0]  run_y0;
    logic [8:0]  run_w;
    logic [8:0]  run_h;
    logic [23:0] run_color;

    // Clipped bounds (exclusive) and current pixel
    logic [8:0]  x_end;
    logic [8:0]  y_end;
    logic [8:0]  x_cnt;
    logic [8:0]  y_cnt;

    fill_state_t state;

    logic        start_req;
    logic        clip_empty;
    logic [8:0]  x_sum;
    logic [8:0]  y_sum;
    logic        xfer;
    logic        row_last;
    logic        col_last;

    // Bits of the write bus no register keeps.
    logic unused_cfg_bits;
    assign unused_cfg_bits = &{1'b0, cfg_data_write[31:24]};

    assign start_req = cfg_write_enable && (cfg_address == REG_CTRL) &&
                       cfg_data_write[CTRL_START_BIT];

    // 9-bit sums cannot overflow: max X0+W = 127+255, max Y0+H = 63+127.
    assign x_sum      = run_x0 + run_w;
    assign y_sum      = run_y0 + run_h;
    assign clip_empty = (run_w == 9'd0) || (run_h == 9'd0) ||
                        (run_x0 >= FBW9) || (run_y0 >= FBH9);

    assign xfer     = fb_write_enable && fb_ready;
    assign col_last = (x_cnt == x_end - 9'd1);
    assign row_last = (y_cnt == y_end - 9'd1);

    // FB_WIDTH is a power of two, so y*FB_WIDTH+x is just {y,x}.
    function automatic logic [ADDRESS_WIDTH-1:0] pixel_addr(input logic [8:0] x,
                                                            input logic [8:0] y);
        return (ADDRESS_WIDTH'(y) << XW) | ADDRESS_WIDTH'(x);
    endfunction

    always_comb begin
        cfg_data_read = 32'h0;
        case (cfg_address)
            REG_X0:     cfg_data_read = {25'h0, x0_q};
            REG_Y0:     cfg_data_read = {26'h0, y0_q};
            REG_W:      cfg_data_read = {24'h0, w_q};
            REG_H:      cfg_data_read = {25'h0, h_q};
            REG_COLOR:  cfg_data_read = {8'h0, color_q};
            REG_STATUS: cfg_data_read = {30'h0, busy, done_q};
            default:    cfg_data_read = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x0_q            <= '0;
            y0_q            <= '0;
            w_q             <= '0;
            h_q             <= '0;
            color_q         <= '0;
            done_q          <= 1'b0;
            run_x0          <= '0;
            run_y0          <= '0;
            run_w           <= '0;
            run_h           <= '0;
            run_color       <= '0;
            x_end           <= '0;
            y_end           <= '0;
            x_cnt           <= '0;
            y_cnt           <= '0;
            state           <= ST_IDLE;
            busy            <= 1'b0;
            done_irq        <= 1'b0;
            fb_write_enable <= 1'b0;
            fb_address      <= '0;
            fb_data_write   <= '0;
        end else begin
            done_irq <= 1'b0;

            if (cfg_write_enable) begin
                case (cfg_address)
                    REG_X0:     x0_q    <= cfg_data_write[6:0];
                    REG_Y0:     y0_q    <= cfg_data_write[5:0];
                    REG_W:      w_q     <= cfg_data_write[7:0];
                    REG_H:      h_q     <= cfg_data_write[6:0];
                    REG_COLOR:  color_q <= cfg_data_write[23:0];
                    REG_STATUS: if (cfg_data_write[STATUS_CLEAR_BIT]) done_q <= 1'b0;
                    default: ;
                endcase
            end

            // done_q set assignments below come later in the block, so a
            // same-cycle clear loses to the set.
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        run_x0    <= {2'b00, x0_q};
                        run_y0    <= {3'b000, y0_q};
                        run_w     <= {1'b0, w_q};
                        run_h     <= {2'b00, h_q};
                        run_color <= color_q;
                        busy      <= 1'b1;
                        state     <= ST_CLIP;
                    end
                end

                ST_CLIP: begin
                    if (clip_empty) begin
                        done_irq <= 1'b1;
                        done_q   <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        x_end           <= (x_sum > FBW9) ? FBW9 : x_sum;
                        y_end           <= (y_sum > FBH9) ? FBH9 : y_sum;
                        x_cnt           <= run_x0;
                        y_cnt           <= run_y0;
                        fb_address      <= pixel_addr(run_x0, run_y0);
                        fb_data_write   <= pack_pixel(run_color);
                        fb_write_enable <= 1'b1;
                        state           <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (xfer) begin
                        if (col_last) begin
                            if (row_last) begin
                                fb_write_enable <= 1'b0;
                                done_irq        <= 1'b1;
                                done_q          <= 1'b1;
                                state           <= ST_DONE;
                            end else begin
                                x_cnt      <= run_x0;
                                y_cnt      <= y_cnt + 9'd1;
                                fb_address <= pixel_addr(run_x0, y_cnt + 9'd1);
                            end
                        end else begin
                            x_cnt      <= x_cnt + 9'd1;
                            fb_address <= pixel_addr(x_cnt + 9'd1, y_cnt);
                        end
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gfx_fill_engine.sv
module tb_gfx_fill_engine;
    import gfx_pkg::*;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    cfg_address;
    logic [31:0]   cfg_data_write;
    logic          cfg_write_enable;
    logic [31:0]   cfg_data_read;
    logic [AW-1:0] fb_address;
    logic [31:0]   fb_data_write;
    logic          fb_write_enable;
    logic          fb_ready;
    logic          busy;
    logic          done_irq;

    always #5 clk = ~clk;

    gfx_fill_engine #(.ADDRESS_WIDTH(AW), .FB_WIDTH(128), .FB_HEIGHT(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_address      (cfg_address),
        .cfg_data_write   (cfg_data_write),
        .cfg_write_enable (cfg_write_enable),
        .cfg_data_read    (cfg_data_read),
        .fb_address       (fb_address),
        .fb_data_write    (fb_data_write),
        .fb_write_enable  (fb_write_enable),
        .fb_ready         (fb_ready),
        .busy             (busy),
        .done_irq         (done_irq)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int addr, input logic [31:0] data);
        exp_t e;
        e.addr = AW'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted write is popped against the scoreboard; stalled
    // writes must hold address and data until taken. Reset overrides any transfer.
    initial begin
        logic          stall_prev;
        logic [AW-1:0] held_addr;
        logic [31:0]   held_data;
        exp_t          e;
        stall_prev = 1'b0;
        held_addr  = '0;
        held_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (done_irq) done_cnt++;
                if (stall_prev && fb_write_enable) begin
                    check("hold_addr", 64'(fb_address), 64'(held_addr));
                    check("hold_data", 64'(fb_data_write), 64'(held_data));
                end
                if (fb_write_enable && fb_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                                 fb_address, fb_data_write);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 64'(fb_address), 64'(e.addr));
                        check("wr_data", 64'(fb_data_write), 64'(e.data));
                    end
                end
                stall_prev = fb_write_enable && !fb_ready;
                held_addr  = fb_address;
                held_data  = fb_data_write;
            end
        end
    end

    // All stimulus is driven 1ns after a rising edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cfg_address      = a;
        cfg_data_write   = d;
        cfg_write_enable = 1'b1;
        @(posedge clk);
        #1;
        cfg_write_enable = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] req);
        cfg_address = a;
        @(negedge clk);
        check(name, 64'(cfg_data_read), 64'(req));
        @(posedge clk);
        #1;
    endtask

    // Counts falling edges until done_irq; reports where fb_write_enable first
    // appeared and how many sampled cycles had busy high.
    task automatic wait_done(input int budget, input bit toggle_ready,
                             output int n_cyc, output int first_we, output int busy_cyc);
        bit seen;
        seen     = 1'b0;
        n_cyc    = 0;
        first_we = 0;
        busy_cyc = 0;
        while (!seen && n_cyc < budget) begin
            @(negedge clk);
            n_cyc++;
            if (busy) busy_cyc++;
            if (fb_write_enable && first_we == 0) first_we = n_cyc;
            if (done_irq) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                if (toggle_ready) fb_ready = ~fb_ready;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_done: no done_irq within %0d cycles", budget);
        end
        @(posedge clk);
        #1;
        fb_ready = 1'b1;
    endtask

    task automatic set_rect(input int x0, input int y0, input int w, input int h,
                            input logic [31:0] color);
        wr(REG_X0, 32'(x0));
        wr(REG_Y0, 32'(y0));
        wr(REG_W, 32'(w));
        wr(REG_H, 32'(h));
        wr(REG_COLOR, color);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, fwe, bcyc, d0, guard;

        reset            = 1'b1;
        cfg_address      = 3'd0;
        cfg_data_write   = 32'h0;
        cfg_write_enable = 1'b0;
        fb_ready         = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        @(negedge clk);
        check("rst_we", 64'(fb_write_enable), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_irq", 64'(done_irq), 64'd0);
        check("rst_addr", 64'(fb_address), 64'd0);
        check("rst_data", 64'(fb_data_write), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd_check("rst_status", REG_STATUS, 32'h0);

        // Basic 3x2 fill; upper write bits must be dropped
        wr(REG_X0, 32'h0000_008A);
        wr(REG_Y0, 32'h0000_0005);
        wr(REG_W, 32'hFFFF_FF03);
        wr(REG_H, 32'h0000_0002);
        wr(REG_COLOR, 32'hABFF_0000);
        rd_check("rd_x0", REG_X0, 32'd10);
        rd_check("rd_w", REG_W, 32'd3);
        rd_check("rd_color", REG_COLOR, 32'h00FF_0000);
        rd_check("rd_ctrl", REG_CTRL, 32'h0);
        rd_check("rd_addr7", 3'd7, 32'h0);
        push_exp(650, 32'h00FF_0000);
        push_exp(651, 32'h00FF_0000);
        push_exp(652, 32'h00FF_0000);
        push_exp(778, 32'h00FF_0000);
        push_exp(779, 32'h00FF_0000);
        push_exp(780, 32'h00FF_0000);
        d0 = done_cnt;
        wr(REG_CTRL, 32'h1);
        wait_done(100, 1'b0, n, fwe, bcyc);
        check("t1_first_we", 64'(fwe), 64'd2);
        check("t1_done_lat", 64'(n), 64'd8);
        repeat (3) @(posedge clk);
        #1;
        check("t1_irq_once", 64'(done_cnt - d0), 64'd1);
        check("t1_left", 64'(exp_q.size()), 64'd0);
        rd_check("t1_status", REG_STATUS, 32'h1);

        // Clipped at the bottom-right corner
        set_rect(126, 62, 10, 10, 32'h0000_00FF);
        push_exp(8062, 32'h0000_00FF);
        push_exp(8063, 32'h0000_00FF);
        push_exp(8190, 32'h0000_00FF);
        push_exp(8191, 32'h0000_00FF);
        wr(REG_CTRL, 32'h1);
        wait_done(100, 1'b0, n, fwe, bcyc);
        check("t2_done_lat", 64'(n), 64'd6);
        check("t2_left", 64'(exp_q.size()), 64'd0);

        // Empty rectangle: no writes, done two cycles after start
        set_rect(4, 4, 0, 3, 32'h0012_3456);
        d0 = done_cnt;
        wr(REG_CTRL, 32'h1);
        wait_done(20, 1'b0, n, fwe, bcyc);
        check("t3_done_lat", 64'(n), 64'd2);
        check("t3_busy_cyc", 64'(bcyc), 64'd2);
        check("t3_no_we", 64'(fwe), 64'd0);
        @(negedge clk);
        check("t3_busy_off", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check("t3_irq_once", 64'(done_cnt - d0), 64'd1);

        // fb_ready toggling every cycle on a 4x1 fill
        set_rect(0, 0, 4, 1, 32'h0000_AA55);
        push_exp(0, 32'h0000_AA55);
        push_exp(1, 32'h0000_AA55);
        push_exp(2, 32'h0000_AA55);
        push_exp(3, 32'h0000_AA55);
        wr(REG_CTRL, 32'h1);
        wait_done(100, 1'b1, n, fwe, bcyc);
        check("t4_left", 64'(exp_q.size()), 64'd0);

        // Reset after the third write of an 8x8 fill
        set_rect(0, 0, 8, 8, 32'h0000_FF00);
        push_exp(0, 32'h0000_FF00);
        push_exp(1, 32'h0000_FF00);
        push_exp(2, 32'h0000_FF00);
        wr(REG_CTRL, 32'h1);
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
            if (exp_q.size() != 0) begin
                @(posedge clk);
                #1;
            end
        end
        check("t5_three_wr", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_we", 64'(fb_write_enable), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_addr", 64'(fb_address), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd_check("t5_w", REG_W, 32'h0);
        rd_check("t5_h", REG_H, 32'h0);
        rd_check("t5_color", REG_COLOR, 32'h0);
        rd_check("t5_status", REG_STATUS, 32'h0);
        repeat (10) @(posedge clk);
        #1;

        // Restart and colour rewrite mid-fill are ignored
        set_rect(20, 10, 2, 2, 32'h0012_3456);
        push_exp(1300, 32'h0012_3456);
        push_exp(1301, 32'h0012_3456);
        push_exp(1428, 32'h0012_3456);
        push_exp(1429, 32'h0012_3456);
        d0 = done_cnt;
        wr(REG_CTRL, 32'h1);
        wr(REG_COLOR, 32'h00AB_CDEF);
        wr(REG_CTRL, 32'h1);
        wait_done(100, 1'b0, n, fwe, bcyc);
        check("t6_left", 64'(exp_q.size()), 64'd0);
        rd_check("t6_status", REG_STATUS, 32'h1);
        rd_check("t6_color", REG_COLOR, 32'h00AB_CDEF);
        wr(REG_STATUS, 32'h1);
        rd_check("t6_status_keep", REG_STATUS, 32'h1);
        wr(REG_STATUS, 32'h2);
        rd_check("t6_status_clr", REG_STATUS, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check("t6_irq_once", 64'(done_cnt - d0), 64'd1);
        check("t6_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
